// File: rtl/enemy_sched_pkg.sv
// Shared definitions for the enemy scheduler slice: FSM encoding, movement
// directions used by the enemy datapath, and pixel field widths.
package enemy_sched_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_HIT   = 3'd2,
        S_GEN   = 3'd3,
        S_APPLY = 3'd4,
        S_DRAW  = 3'd5,
        S_GAP   = 3'd6,
        S_DONE  = 3'd7
    } sched_state_t;

    typedef enum logic [2:0] {
        NO_ACTION = 3'd0,
        UP        = 3'd1,
        DOWN      = 3'd2,
        LEFT      = 3'd3,
        RIGHT     = 3'd4
    } direction_t;

    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned COLOUR_W = 6;

    // Bit offset of slice idx inside a packed per-instance bus.
    function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/enemy_scheduler_if.sv
// Bundle of per-enemy strobes and pixel buses between the scheduler (master)
// and the bank of enemy datapaths (slave).
interface enemy_scheduler_if #(
    parameter int unsigned N_ENEMIES = 4
);
    import enemy_sched_pkg::*;

    logic [N_ENEMIES-1:0]          en_init;
    logic [N_ENEMIES-1:0]          en_idle;
    logic [N_ENEMIES-1:0]          en_hit;
    logic [N_ENEMIES-1:0]          en_gen_move;
    logic [N_ENEMIES-1:0]          en_apply_move;
    logic [N_ENEMIES-1:0]          en_draw;
    logic [N_ENEMIES-1:0]          en_draw_done;
    logic [X_W*N_ENEMIES-1:0]      en_x_draw;
    logic [Y_W*N_ENEMIES-1:0]      en_y_draw;
    logic [COLOUR_W*N_ENEMIES-1:0] en_colour;
    logic [N_ENEMIES-1:0]          en_vga_write;

    modport master (
        output en_init, en_idle, en_hit, en_gen_move, en_apply_move, en_draw,
        input  en_draw_done, en_x_draw, en_y_draw, en_colour, en_vga_write
    );

    modport slave (
        input  en_init, en_idle, en_hit, en_gen_move, en_apply_move, en_draw,
        output en_draw_done, en_x_draw, en_y_draw, en_colour, en_vga_write
    );

endinterface

// File: rtl/enemy_vga_mux.sv
// N-way selector over a packed bus of equal-width slices; slice sel is routed
// to the output. Out-of-range sel yields zero.
module enemy_vga_mux
    import enemy_sched_pkg::*;
#(
    parameter int unsigned N_WAYS = 4,
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned SEL_W  = 3
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [WIDTH*N_WAYS-1:0] packed_bus,
    output logic [WIDTH-1:0]        selected
);

    always_comb begin
        selected = '0;
        for (int unsigned i = 0; i < N_WAYS; i++) begin
            if (sel == SEL_W'(i)) begin
                selected = packed_bus[field_lsb(i, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/enemy_scheduler.sv
// Frame-level sequencer for a bank of enemy datapaths: issues the per-frame
// state strobes and grants the shared VGA pixel port to one enemy at a time.
module enemy_scheduler
    import enemy_sched_pkg::*;
#(
    parameter int unsigned N_ENEMIES    = 4,
    parameter int unsigned DRAW_TIMEOUT = 300,
    parameter int unsigned IDX_W        = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic [N_ENEMIES-1:0] hit_req,
    enemy_scheduler_if.master    bank,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [COLOUR_W-1:0]  vga_colour,
    output logic                 vga_write,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 timeout_err
);

    localparam int unsigned      WD_W     = $clog2(DRAW_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_SEL = IDX_W'(N_ENEMIES - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(DRAW_TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MIN   = WD_W'(2);

    sched_state_t         state;
    logic [N_ENEMIES-1:0] hit_pend;
    logic [IDX_W-1:0]     sel;
    logic [WD_W-1:0]      wd_cnt;
    logic                 done_sel;
    logic                 write_sel;
    logic                 done_ok;
    logic                 timed_out;

    function automatic logic [N_ENEMIES-1:0] grant_of(input logic [IDX_W-1:0] idx);
        logic [N_ENEMIES-1:0] g;
        g = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++) begin
            g[i] = (idx == IDX_W'(i));
        end
        return g;
    endfunction

    enemy_vga_mux #(.N_WAYS(N_ENEMIES), .WIDTH(X_W), .SEL_W(IDX_W)) u_mux_x (
        .sel(sel), .packed_bus(bank.en_x_draw), .selected(vga_x)
    );

    enemy_vga_mux #(.N_WAYS(N_ENEMIES), .WIDTH(Y_W), .SEL_W(IDX_W)) u_mux_y (
        .sel(sel), .packed_bus(bank.en_y_draw), .selected(vga_y)
    );

    enemy_vga_mux #(.N_WAYS(N_ENEMIES), .WIDTH(COLOUR_W), .SEL_W(IDX_W)) u_mux_colour (
        .sel(sel), .packed_bus(bank.en_colour), .selected(vga_colour)
    );

    enemy_vga_mux #(.N_WAYS(N_ENEMIES), .WIDTH(1), .SEL_W(IDX_W)) u_mux_write (
        .sel(sel), .packed_bus(bank.en_vga_write), .selected(write_sel)
    );

    enemy_vga_mux #(.N_WAYS(N_ENEMIES), .WIDTH(1), .SEL_W(IDX_W)) u_mux_done (
        .sel(sel), .packed_bus(bank.en_draw_done), .selected(done_sel)
    );

    // A done still high from the previous grant is ignored for the first two cycles.
    always_comb begin
        done_ok   = done_sel && (wd_cnt >= WD_MIN);
        timed_out = (wd_cnt == WD_LAST);
        busy      = (state != S_IDLE);
        vga_write = write_sel && (state == S_DRAW);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_INIT;
            bank.en_init       <= '0;
            bank.en_idle       <= '0;
            bank.en_hit        <= '0;
            bank.en_gen_move   <= '0;
            bank.en_apply_move <= '0;
            bank.en_draw       <= '0;
            frame_done         <= 1'b0;
            timeout_err        <= 1'b0;
            hit_pend           <= '0;
            sel                <= '0;
            wd_cnt             <= '0;
        end else begin
            bank.en_init       <= '0;
            bank.en_hit        <= '0;
            bank.en_gen_move   <= '0;
            bank.en_apply_move <= '0;
            frame_done         <= 1'b0;
            hit_pend           <= hit_pend | hit_req;

            case (state)
                // Reset leaves en_init low, so S_INIT spends one cycle raising it
                // and leaves on the next; the strobe is high for exactly one cycle.
                S_INIT: begin
                    if (!bank.en_init[0]) begin
                        bank.en_init <= '1;
                    end else begin
                        state        <= S_IDLE;
                        bank.en_idle <= '1;
                    end
                end
                S_IDLE: begin
                    if (frame_tick) begin
                        state        <= S_HIT;
                        bank.en_idle <= '0;
                        bank.en_hit  <= hit_pend | hit_req;
                    end
                end
                S_HIT: begin
                    hit_pend         <= hit_req;
                    state            <= S_GEN;
                    bank.en_gen_move <= '1;
                end
                S_GEN: begin
                    state              <= S_APPLY;
                    bank.en_apply_move <= '1;
                end
                S_APPLY: begin
                    sel          <= '0;
                    wd_cnt       <= '0;
                    state        <= S_DRAW;
                    bank.en_draw <= grant_of('0);
                end
                S_DRAW: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (done_ok || timed_out) begin
                        bank.en_draw <= '0;
                        if (!done_ok) begin
                            timeout_err <= 1'b1;
                        end
                        if (sel == LAST_SEL) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    sel          <= sel + 1'b1;
                    wd_cnt       <= '0;
                    state        <= S_DRAW;
                    bank.en_draw <= grant_of(sel + 1'b1);
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    bank.en_idle <= '1;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enemy_scheduler.sv
// Scoreboard bench for enemy_scheduler: behavioural enemies answer draw grants,
// expected grants and hit vectors are queued and popped as the DUT shows them.
module tb_enemy_scheduler;
    import enemy_sched_pkg::*;

    localparam int N       = 4;
    localparam int TMO     = 300;
    localparam int DONE_AT = 257;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                frame_tick = 1'b0;
    logic [N-1:0]        hit_req = '0;
    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_write;
    logic                busy;
    logic                frame_done;
    logic                timeout_err;

    enemy_scheduler_if #(.N_ENEMIES(N)) bank ();

    enemy_scheduler #(.N_ENEMIES(N), .DRAW_TIMEOUT(TMO), .IDX_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .frame_tick(frame_tick),
        .hit_req(hit_req),
        .bank(bank),
        .vga_x(vga_x),
        .vga_y(vga_y),
        .vga_colour(vga_colour),
        .vga_write(vga_write),
        .busy(busy),
        .frame_done(frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int len;
    } grant_t;

    grant_t       exp_grants[$];
    logic [N-1:0] exp_hits[$];
    int           errors = 0;
    int           checks = 0;
    int           done_at[N];

    // One frame: pulse frame_tick, then follow the DUT cycle by cycle while the
    // enemy model answers grants. Stops early at the first grant of stop_grant.
    task automatic run_frame(input int hit_at, input logic [N-1:0] hit_val,
                             input int tick_at, input logic [N-1:0] hit_in_hit,
                             input bit stale, input int stop_grant, output bit stopped);
        int           gcnt[N];
        logic [N-1:0] prev_draw, nd, h;
        int           cur_idx, cur_len, gap, gen_cnt, apply_cnt, done_cnt, drawn;
        bit           prev_idle, finished, stale_live;
        grant_t       g;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        prev_draw = '0; cur_idx = -1; cur_len = 0; gap = 0;
        gen_cnt = 0; apply_cnt = 0; done_cnt = 0; drawn = 0;
        finished = 0; stopped = 0; stale_live = stale;
        prev_idle = bank.en_idle[0];
        frame_tick = 1'b1;
        if (stale) bank.en_draw_done[0] = 1'b1;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clock);
            frame_tick = 1'b0;
            hit_req = '0;
            if (prev_idle && !bank.en_idle[0]) begin
                checks++;
                if (exp_hits.size() == 0) begin
                    errors++;
                    $display("FAIL hit_queue: S_HIT with no expectation, en_hit=%b", bank.en_hit);
                end else begin
                    h = exp_hits.pop_front();
                    if (bank.en_hit !== h) begin
                        errors++;
                        $display("FAIL en_hit: got %b expected %b", bank.en_hit, h);
                    end
                end
                hit_req = hit_in_hit;
            end
            prev_idle = bank.en_idle[0];
            if (bank.en_gen_move == '1) gen_cnt++;
            if (bank.en_apply_move == '1) apply_cnt++;
            if (frame_done) done_cnt++;
            if (prev_draw != '0 && bank.en_draw != prev_draw) begin
                checks++;
                if (exp_grants.size() == 0) begin
                    errors++;
                    $display("FAIL grant_queue: unexpected grant idx=%0d len=%0d", cur_idx, cur_len);
                end else begin
                    g = exp_grants.pop_front();
                    if (cur_idx != g.idx || cur_len != g.len) begin
                        errors++;
                        $display("FAIL grant: got idx=%0d len=%0d expected idx=%0d len=%0d",
                                 cur_idx, cur_len, g.idx, g.len);
                    end
                end
            end
            if (bank.en_draw != '0) begin
                if (bank.en_draw != prev_draw) begin
                    checks++;
                    if ($countones(bank.en_draw) != 1) begin
                        errors++;
                        $display("FAIL draw_onehot: got %b expected one bit set", bank.en_draw);
                    end
                    if (cur_idx >= 0) begin
                        checks++;
                        if (gap != 1) begin
                            errors++;
                            $display("FAIL gap_len: got %0d expected 1", gap);
                        end
                    end
                    for (int i = 0; i < N; i++) if (bank.en_draw[i]) cur_idx = i;
                    cur_len = 0;
                    if (stop_grant >= 0 && cur_idx == stop_grant) begin
                        stopped = 1;
                        finished = 1;
                    end
                end
                cur_len++;
                drawn++;
                gap = 0;
            end else begin
                gap++;
            end
            if (frame_done) finished = 1;
            for (int i = 0; i < N; i++) begin
                if (bank.en_draw[i]) gcnt[i] = prev_draw[i] ? gcnt[i] + 1 : 0;
                nd[i] = bank.en_draw[i] && done_at[i] >= 0 && gcnt[i] >= done_at[i];
            end
            if (stale_live) begin
                if (bank.en_draw[0] && gcnt[0] >= 2) stale_live = 0;
                else nd[0] = 1'b1;
            end
            bank.en_draw_done = nd;
            if (bank.en_draw != '0 && drawn == hit_at) hit_req = hit_req | hit_val;
            if (bank.en_draw != '0 && drawn == tick_at) frame_tick = 1'b1;
            prev_draw = bank.en_draw;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: frame_done not seen, got busy=%b expected frame end", busy);
        end else if (!stopped) begin
            checks++;
            if (gen_cnt != 1 || apply_cnt != 1 || done_cnt != 1) begin
                errors++;
                $display("FAIL strobe_len: got gen=%0d apply=%0d done=%0d expected 1 1 1",
                         gen_cnt, apply_cnt, done_cnt);
            end
            checks++;
            if (exp_grants.size() != 0) begin
                errors++;
                $display("FAIL grants_left: got %0d unmatched expected 0", exp_grants.size());
            end
            @(negedge clock);
            checks++;
            if (bank.en_idle !== '1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL back_to_idle: got en_idle=%b busy=%b expected 1111 0", bank.en_idle, busy);
            end
        end
        if (!stopped) bank.en_draw_done = '0;
    endtask

    task automatic push_normal_grants();
        for (int i = 0; i < N; i++) exp_grants.push_back('{idx: i, len: DONE_AT + 1});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bank.en_draw_done = '0; bank.en_vga_write = '0;
        bank.en_x_draw = '0; bank.en_y_draw = '0; bank.en_colour = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bank.en_init, bank.en_idle, bank.en_hit, bank.en_gen_move, bank.en_apply_move, bank.en_draw} !== '0) begin
            errors++;
            $display("FAIL reset_strobes: got init=%b idle=%b hit=%b gen=%b apply=%b draw=%b expected all 0",
                     bank.en_init, bank.en_idle, bank.en_hit, bank.en_gen_move, bank.en_apply_move, bank.en_draw);
        end
        checks++;
        if (frame_done !== 1'b0 || timeout_err !== 1'b0 || vga_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got done=%b tmo=%b wr=%b expected 0 0 0", frame_done, timeout_err, vga_write);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (bank.en_init !== '1 || bank.en_idle !== '0) begin
            errors++;
            $display("FAIL init_strobe: got init=%b idle=%b expected 1111 0000", bank.en_init, bank.en_idle);
        end
        @(negedge clock);
        checks++;
        if (bank.en_init !== '0 || bank.en_idle !== '1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_entry: got init=%b idle=%b busy=%b expected 0000 1111 0",
                     bank.en_init, bank.en_idle, busy);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || bank.en_idle !== '1) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b idle=%b expected 0 1111", busy, bank.en_idle);
        end
    endtask

    task automatic test_normal_frame();
        bit s;
        for (int i = 0; i < N; i++) done_at[i] = DONE_AT;
        exp_hits.push_back('0);
        push_normal_grants();
        run_frame(-1, '0, -1, '0, 0, -1, s);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: got timeout_err=%b expected 0", timeout_err);
        end
    endtask

    task automatic test_hit_latency();
        bit s;
        exp_hits.push_back(4'b0000);
        push_normal_grants();
        run_frame(20, 4'b0100, 100, '0, 0, -1, s);
        exp_hits.push_back(4'b0100);
        push_normal_grants();
        run_frame(-1, '0, -1, 4'b0001, 0, -1, s);
        exp_hits.push_back(4'b0001);
        push_normal_grants();
        run_frame(-1, '0, -1, '0, 0, -1, s);
        exp_hits.push_back(4'b0000);
        push_normal_grants();
        run_frame(-1, '0, -1, '0, 0, -1, s);
    endtask

    task automatic test_stale_done();
        bit s;
        exp_hits.push_back('0);
        push_normal_grants();
        run_frame(-1, '0, -1, '0, 1, -1, s);
    endtask

    task automatic test_timeout();
        bit s;
        done_at[1] = -1;
        exp_hits.push_back('0);
        exp_grants.push_back('{idx: 0, len: DONE_AT + 1});
        exp_grants.push_back('{idx: 1, len: TMO});
        exp_grants.push_back('{idx: 2, len: DONE_AT + 1});
        exp_grants.push_back('{idx: 3, len: DONE_AT + 1});
        run_frame(-1, '0, -1, '0, 0, -1, s);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: got timeout_err=%b expected 1", timeout_err);
        end
        done_at[1] = DONE_AT;
        exp_hits.push_back('0);
        push_normal_grants();
        run_frame(-1, '0, -1, '0, 0, -1, s);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got timeout_err=%b expected 1", timeout_err);
        end
    endtask

    task automatic test_mux_and_reset();
        bit s;
        exp_hits.push_back('0);
        exp_grants.push_back('{idx: 0, len: DONE_AT + 1});
        exp_grants.push_back('{idx: 1, len: DONE_AT + 1});
        run_frame(10, 4'b0100, -1, '0, 0, 2, s);
        checks++;
        if (!s) begin
            errors++;
            $display("FAIL reach_sel2: got no grant to enemy 2 expected en_draw=0100");
        end
        for (int i = 0; i < N; i++) begin
            bank.en_x_draw[i*X_W +: X_W] = 9'h0D0 + 9'(i);
            bank.en_y_draw[i*Y_W +: Y_W] = 8'h40 + 8'(i);
            bank.en_colour[i*COLOUR_W +: COLOUR_W] = 6'h10 + 6'(i);
        end
        bank.en_vga_write = 4'b1011;
        #1;
        checks++;
        if (vga_write !== 1'b0) begin
            errors++;
            $display("FAIL mux_write_off: got vga_write=%b expected 0", vga_write);
        end
        bank.en_vga_write = 4'b0100;
        #1;
        checks++;
        if (vga_x !== 9'h0D2 || vga_y !== 8'h42 || vga_colour !== 6'h12 || vga_write !== 1'b1) begin
            errors++;
            $display("FAIL mux_sel2: got x=%h y=%h c=%h wr=%b expected 0d2 42 12 1",
                     vga_x, vga_y, vga_colour, vga_write);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (bank.en_draw !== '0 || vga_write !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_draw: got draw=%b wr=%b tmo=%b expected 0000 0 0",
                     bank.en_draw, vga_write, timeout_err);
        end
        reset = 1'b0;
        bank.en_draw_done = '0;
        bank.en_vga_write = '0;
        @(negedge clock);
        checks++;
        if (bank.en_init !== '1) begin
            errors++;
            $display("FAIL restart_init: got en_init=%b expected 1111", bank.en_init);
        end
        @(negedge clock);
        exp_hits.push_back('0);
        push_normal_grants();
        run_frame(-1, '0, -1, '0, 0, -1, s);
    endtask

    initial begin
        test_reset();
        test_normal_frame();
        test_hit_latency();
        test_stale_done();
        test_timeout();
        test_mux_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
